// File: rtl/channel_scheduler_pkg.sv
// Shared types and default sizing for the channel scheduler.
package channel_scheduler_pkg;

  localparam int N_CHANNELS_DEF = 4;
  localparam int DIV_RATIO_DEF  = 8;
  localparam int CH_WIDTH_DEF   = 9;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } sched_state_e;

endpackage

// File: rtl/channel_scheduler_if.sv
// Output word stream of the scheduler: valid/ready handshake with channel tag.
interface channel_scheduler_if
  import channel_scheduler_pkg::*;
#(
  parameter int N_CHANNELS = N_CHANNELS_DEF,
  parameter int CH_WIDTH   = CH_WIDTH_DEF
) ();

  logic                          out_valid;
  logic                          out_ready;
  logic [CH_WIDTH-1:0]           out_data;
  logic [$clog2(N_CHANNELS)-1:0] out_ch;

  modport master (output out_valid, output out_data, output out_ch, input out_ready);
  modport slave  (input out_valid, input out_data, input out_ch, output out_ready);

endinterface

// File: rtl/channel_scheduler_frame_divider.sv
// Frame divider: free-running modulo-DIV_RATIO counter gated by enable, with a
// strobe in the last count of each frame.
module frame_divider #(
  parameter int DIV_RATIO = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic frame_tick
);

  localparam int CNT_W = (DIV_RATIO > 1) ? $clog2(DIV_RATIO) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV_RATIO - 1);

  logic [CNT_W-1:0] div_cnt_r;

  // Count while enabled, park at zero otherwise so a restart is a full frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_r <= '0;
    end else if (!enable) begin
      div_cnt_r <= '0;
    end else if (div_cnt_r == CNT_MAX) begin
      div_cnt_r <= '0;
    end else begin
      div_cnt_r <= div_cnt_r + 1'b1;
    end
  end

  assign frame_tick = enable && (div_cnt_r == CNT_MAX);

endmodule

// File: rtl/channel_scheduler.sv
// Captures a frame of channel samples on each frame tick and emits the
// masked channels one word at a time, lowest index first.
module channel_scheduler
  import channel_scheduler_pkg::*;
#(
  parameter int N_CHANNELS = N_CHANNELS_DEF,
  parameter int DIV_RATIO  = DIV_RATIO_DEF,
  parameter int CH_WIDTH   = CH_WIDTH_DEF
) (
  input  logic                           CLK_24M,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [N_CHANNELS-1:0]          ch_mask,
  input  logic [N_CHANNELS*CH_WIDTH-1:0] channel_data,
  output logic                           frame_tick,
  output logic                           overrun,
  input  logic                           overrun_clr,
  channel_scheduler_if.master            out_if
);

  localparam int CH_IDX_W = $clog2(N_CHANNELS);

  sched_state_e                  state_r, state_s;
  logic [N_CHANNELS-1:0]          pending_r, pending_s, pending_left_s;
  logic [N_CHANNELS*CH_WIDTH-1:0] snapshot_r, snapshot_s;
  logic [CH_IDX_W-1:0]            out_ch_r, sel_idx_s;
  logic [CH_WIDTH-1:0]            out_data_r, sel_data_s;
  logic                           overrun_r, overrun_set_s;
  logic                           frame_tick_s, accept_s;

  frame_divider #(.DIV_RATIO(DIV_RATIO)) u_frame_divider (
    .clk        (CLK_24M),
    .rst_n      (reset),
    .enable     (enable),
    .frame_tick (frame_tick_s)
  );

  assign accept_s = (state_r == SEND) && out_if.out_ready;

  // Next pending set / snapshot: a tick only captures once the previous frame
  // has fully drained (including a final word accepted this very cycle).
  always_comb begin
    pending_left_s = pending_r;
    if (accept_s) begin
      pending_left_s[out_ch_r] = 1'b0;
    end else begin
      pending_left_s = pending_r;
    end
    pending_s     = pending_left_s;
    snapshot_s    = snapshot_r;
    overrun_set_s = 1'b0;
    if (frame_tick_s) begin
      if (pending_left_s == '0) begin
        if (ch_mask != '0) begin
          pending_s  = ch_mask;
          snapshot_s = channel_data;
        end else begin
          pending_s  = pending_left_s;
        end
      end else begin
        overrun_set_s = 1'b1;
      end
    end else begin
      overrun_set_s = 1'b0;
    end
    state_s = (pending_s != '0) ? SEND : IDLE;
  end

  // Lowest-index pending channel of the next cycle, so the output word is registered.
  always_comb begin
    sel_idx_s = '0;
    for (int k = N_CHANNELS - 1; k >= 0; k--) begin
      sel_idx_s = pending_s[k] ? CH_IDX_W'(k) : sel_idx_s;
    end
    sel_data_s = (pending_s != '0) ? snapshot_s[int'(sel_idx_s)*CH_WIDTH +: CH_WIDTH] : '0;
  end

  // Scheduler state, snapshot, output word and sticky overrun.
  always_ff @(posedge CLK_24M or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      pending_r  <= '0;
      snapshot_r <= '0;
      out_ch_r   <= '0;
      out_data_r <= '0;
      overrun_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      pending_r  <= pending_s;
      snapshot_r <= snapshot_s;
      out_ch_r   <= sel_idx_s;
      out_data_r <= sel_data_s;
      if (overrun_set_s) begin
        overrun_r <= 1'b1;
      end else if (overrun_clr) begin
        overrun_r <= 1'b0;
      end else begin
        overrun_r <= overrun_r;
      end
    end
  end

  assign frame_tick       = frame_tick_s;
  assign overrun          = overrun_r;
  assign out_if.out_valid = (state_r == SEND);
  assign out_if.out_ch    = out_ch_r;
  assign out_if.out_data  = out_data_r;

endmodule

// File: tb/tb_channel_scheduler.sv
// Self-checking bench for channel_scheduler: directed tables and sequences plus
// randomized traffic against a queue-based reference model.
module tb_channel_scheduler;
  import channel_scheduler_pkg::*;

  localparam int NC = 4;
  localparam int DR = 8;
  localparam int CW = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n, enable, overrun_clr, frame_tick, overrun;
  logic [NC-1:0]        ch_mask;
  logic [NC*CW-1:0]     channel_data;

  channel_scheduler_if #(.N_CHANNELS(NC), .CH_WIDTH(CW)) bus ();

  channel_scheduler #(.N_CHANNELS(NC), .DIV_RATIO(DR), .CH_WIDTH(CW)) dut (
    .CLK_24M      (clk),
    .reset        (rst_n),
    .enable       (enable),
    .ch_mask      (ch_mask),
    .channel_data (channel_data),
    .frame_tick   (frame_tick),
    .overrun      (overrun),
    .overrun_clr  (overrun_clr),
    .out_if       (bus)
  );

  // Reference model: queue of channels still to send, frozen frame samples,
  // and the number of consecutive enabled cycles since the divider restarted.
  int            q[$];
  logic [CW-1:0] snap[NC];
  int            en_run;
  bit            m_ovr;
  int            checks, errors, cyc;

  typedef struct {
    logic ready;
    logic tick;
    logic valid;
    int   ch;
    int   data;
  } vec_t;
  vec_t tbl[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit model_tick();
    return enable && ((en_run % DR) == DR - 1);
  endfunction

  task automatic model_clear();
    q.delete();
    for (int k = 0; k < NC; k++) snap[k] = '0;
    en_run = 0;
    m_ovr  = 1'b0;
  endtask

  // Sample just after the falling edge and compare against the model.
  task automatic pre();
    cyc++;
    #1;
    check("tick", 32'(frame_tick), 32'(model_tick()));
    check("valid", 32'(bus.out_valid), 32'(q.size() > 0));
    check("ch", 32'(bus.out_ch), (q.size() > 0) ? 32'(q[0]) : 32'd0);
    check("data", 32'(bus.out_data), (q.size() > 0) ? 32'(snap[q[0]]) : 32'd0);
    check("overrun", 32'(overrun), 32'(m_ovr));
  endtask

  // Advance the model with the current inputs, then move to the next falling edge.
  task automatic post();
    bit tick, set;
    tick = model_tick();
    set  = 1'b0;
    if (q.size() > 0 && bus.out_ready) void'(q.pop_front());
    if (tick) begin
      if (q.size() == 0) begin
        if (ch_mask != '0) begin
          for (int k = 0; k < NC; k++) begin
            snap[k] = channel_data[k*CW +: CW];
            if (ch_mask[k]) q.push_back(k);
          end
        end
      end else begin
        set = 1'b1;
      end
    end
    if (set) m_ovr = 1'b1;
    else if (overrun_clr) m_ovr = 1'b0;
    en_run = enable ? en_run + 1 : 0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_ch", 32'(bus.out_ch), 32'd0);
    check("rst_data", 32'(bus.out_data), 32'd0);
    check("rst_tick", 32'(frame_tick), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    model_clear();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
  endtask

  initial begin
    int nv;
    checks = 0; errors = 0; cyc = 0;
    rst_n = 1'b0; enable = 1'b0; overrun_clr = 1'b0; bus.out_ready = 1'b0;
    ch_mask = '0; channel_data = '0;
    model_clear();
    @(negedge clk);

    // Basic frame: four channels, drained back-to-back.
    enable = 1'b1; ch_mask = 4'b1111; bus.out_ready = 1'b1;
    channel_data = {9'h004, 9'h003, 9'h002, 9'h001};
    do_reset();
    for (int i = 0; i < 13; i++) tbl[i] = '{1'b1, 1'b0, 1'b0, 0, 0};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 0, 0};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 0, 1};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 1, 2};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 2, 3};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 3, 4};
    for (int i = 0; i < 13; i++) begin
      bus.out_ready = tbl[i].ready;
      pre();
      check("tbl_tick", 32'(frame_tick), 32'(tbl[i].tick));
      check("tbl_valid", 32'(bus.out_valid), 32'(tbl[i].valid));
      check("tbl_ch", 32'(bus.out_ch), 32'(tbl[i].ch));
      check("tbl_data", 32'(bus.out_data), 32'(tbl[i].data));
      post();
    end

    // Sparse mask: only odd channels, consecutive words.
    ch_mask = 4'b1010; channel_data = {9'h1F0, 9'h0A5, 9'h15A, 9'h033};
    do_reset();
    nv = 0;
    for (int i = 1; i <= 14; i++) begin
      pre();
      if (bus.out_valid) begin
        nv++;
        check("odd_ch", 32'(bus.out_ch), (nv == 1) ? 32'd1 : 32'd3);
      end
      post();
    end
    check("odd_words", 32'(nv), 32'd2);

    // Stalled consumer: held word, dropped frames, clear losing to a set.
    ch_mask = 4'b1111; channel_data = {9'h100, 9'h0FF, 9'h1FF, 9'h180};
    bus.out_ready = 1'b0;
    do_reset();
    for (int i = 1; i <= 34; i++) begin
      bus.out_ready = (i > 28);
      overrun_clr   = (i == 24) || (i == 26);
      if (i == 12) channel_data = {9'h011, 9'h022, 9'h033, 9'h044};
      pre();
      if (i == 17 || i == 25) check("ovr_set", 32'(overrun), 32'd1);
      if (i == 27) check("ovr_clr", 32'(overrun), 32'd0);
      if (i == 28) check("held_data", 32'(bus.out_data), 32'h180);
      post();
    end
    overrun_clr = 1'b0;

    // Final word accepted on a tick: next frame follows with no gap.
    channel_data = {9'h004, 9'h003, 9'h002, 9'h001};
    bus.out_ready = 1'b0;
    do_reset();
    for (int i = 1; i <= 20; i++) begin
      bus.out_ready = (i >= 13);
      if (i == 16) channel_data = {9'h1AA, 9'h155, 9'h0CC, 9'h0AB};
      pre();
      if (i == 16) check("bt_tick_last", 32'({frame_tick, bus.out_valid, bus.out_ch}), 32'h0F);
      if (i == 17) begin
        check("bt_next_valid", 32'(bus.out_valid), 32'd1);
        check("bt_next_data", 32'(bus.out_data), 32'h0AB);
        check("bt_no_ovr", 32'(overrun), 32'd0);
      end
      post();
    end

    // Reset in the middle of a frame.
    bus.out_ready = 1'b1;
    do_reset();
    for (int i = 1; i <= 11; i++) begin
      pre();
      if (i == 11) check("mid_ch2", 32'(bus.out_ch), 32'd2);
      if (i < 11) post();
    end
    do_reset();
    nv = 0;
    for (int i = 1; i <= 10; i++) begin
      pre();
      if (bus.out_valid && nv == 0) begin
        nv = i;
        check("post_rst_ch", 32'(bus.out_ch), 32'd0);
      end
      post();
    end
    check("post_rst_first", 32'(nv), 32'd9);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      enable        = ($urandom_range(0, 9) != 0);
      ch_mask       = NC'($urandom());
      channel_data  = (NC*CW)'({$urandom(), $urandom()});
      bus.out_ready = ($urandom_range(0, 9) < 7);
      overrun_clr   = ($urandom_range(0, 9) == 0);
      pre();
      post();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
